// File: rtl/m84_sample_pkg.sv
// Shared types and constants for the M84 sample playback sequencer.
package m84_sample_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    localparam logic [7:0] DAC_RESET          = 8'h80;
    localparam int         ADDR_SHIFT_DEFAULT = 5;

endpackage

// File: rtl/m84_sample_ctrl.sv
// M84 sample playback sequencer: address latch/step, ROM fetch over req/ack, DAC register.
// Optional one-byte prefetch buffer enabled by `define M84_SAMPLE_PREFETCH_EN.
module m84_sample_ctrl
    import m84_sample_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int ADDR_SHIFT = ADDR_SHIFT_DEFAULT
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic [7:0]        sample_addr,
    input  logic [1:0]        sample_addr_wr,
    input  logic              sample_inc,
    input  logic [7:0]        sample_out,
    output logic [7:0]        sample_in,
    output logic              sample_ready,
    output logic [7:0]        dac_out,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data
);

    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [7:0]        cur_data_q, cur_data_d;
    logic              cur_valid_q, cur_valid_d;
    logic [7:0]        dac_q, dac_d;
    logic              rom_req_q;
    logic              load_s;
    logic              ack_s;
    logic [ADDR_W-1:0] load_addr_s;
`ifdef M84_SAMPLE_PREFETCH_EN
    logic [7:0]        nxt_data_q, nxt_data_d;
    logic              nxt_valid_q, nxt_valid_d;
`endif

    // Next-state logic: address load/step, buffer updates, ack routing and fetch FSM.
    always_comb begin
        lo_d        = lo_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        cur_data_d  = cur_data_q;
        cur_valid_d = cur_valid_q;
        dac_d       = dac_q;
        state_d     = state_q;
`ifdef M84_SAMPLE_PREFETCH_EN
        nxt_data_d  = nxt_data_q;
        nxt_valid_d = nxt_valid_q;
`endif
        load_s = |sample_addr_wr;
        ack_s  = rom_ack && (state_q == REQ);

        if (sample_addr_wr[0]) begin
            lo_d = sample_addr;
        end else begin
            lo_d = lo_q;
        end
        if (sample_addr_wr[1]) begin
            hi_d = sample_addr;
        end else begin
            hi_d = hi_q;
        end
        load_addr_s = ADDR_W'({hi_d, lo_d}) << ADDR_SHIFT;

        if (sample_inc) begin
            dac_d = sample_out;
        end else begin
            dac_d = dac_q;
        end

        // A load overrides a coincident step for the counter.
        if (load_s) begin
            cnt_d       = load_addr_s;
            cur_valid_d = 1'b0;
`ifdef M84_SAMPLE_PREFETCH_EN
            nxt_valid_d = 1'b0;
`endif
        end else if (sample_inc) begin
            cnt_d = cnt_q + CNT_ONE;
`ifdef M84_SAMPLE_PREFETCH_EN
            if (nxt_valid_q) begin
                cur_data_d  = nxt_data_q;
                cur_valid_d = 1'b1;
            end else begin
                cur_valid_d = 1'b0;
            end
            nxt_valid_d = 1'b0;
`else
            cur_valid_d = 1'b0;
`endif
        end else begin
            cnt_d = cnt_q;
        end

        // Route returned data against the address that will be current after this edge.
        if (ack_s && (pend_q == cnt_d)) begin
            cur_data_d  = rom_data;
            cur_valid_d = 1'b1;
`ifdef M84_SAMPLE_PREFETCH_EN
        end else if (ack_s && (pend_q == (cnt_d + CNT_ONE))) begin
            nxt_data_d  = rom_data;
            nxt_valid_d = 1'b1;
`endif
        end else begin
            cur_valid_d = cur_valid_d;
        end

        case (state_q)
            IDLE: begin
                if (!cur_valid_q) begin
                    state_d = REQ;
                    pend_d  = cnt_q;
`ifdef M84_SAMPLE_PREFETCH_EN
                end else if (!nxt_valid_q) begin
                    state_d = REQ;
                    pend_d  = cnt_q + CNT_ONE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lo_q        <= 8'h00;
            hi_q        <= 8'h00;
            cnt_q       <= {ADDR_W{1'b0}};
            pend_q      <= {ADDR_W{1'b0}};
            cur_data_q  <= 8'h00;
            cur_valid_q <= 1'b0;
            dac_q       <= DAC_RESET;
            rom_req_q   <= 1'b0;
`ifdef M84_SAMPLE_PREFETCH_EN
            nxt_data_q  <= 8'h00;
            nxt_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            cur_data_q  <= cur_data_d;
            cur_valid_q <= cur_valid_d;
            dac_q       <= dac_d;
            rom_req_q   <= (state_d == REQ);
`ifdef M84_SAMPLE_PREFETCH_EN
            nxt_data_q  <= nxt_data_d;
            nxt_valid_q <= nxt_valid_d;
`endif
        end
    end

    assign sample_in    = cur_data_q;
    assign sample_ready = cur_valid_q;
    assign dac_out      = dac_q;
    assign rom_addr     = pend_q;
    assign rom_req      = rom_req_q;

endmodule

// File: tb/tb_m84_sample_ctrl.sv
// Self-checking bench for m84_sample_ctrl: directed scenarios plus randomized traffic
// against an address/DAC reference model and a synthetic ROM image.
module tb_m84_sample_ctrl;

    localparam int AW = 18;

    logic          CLK_32M = 1'b0;
    logic          reset_n;
    logic [7:0]    sample_addr;
    logic [1:0]    sample_addr_wr;
    logic          sample_inc;
    logic [7:0]    sample_out;
    logic [7:0]    sample_in;
    logic          sample_ready;
    logic [7:0]    dac_out;
    logic [AW-1:0] rom_addr;
    logic          rom_req;
    logic          rom_ack;
    logic [7:0]    rom_data;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [7:0]    m_lo, m_hi, m_dac;
    logic [AW-1:0] m_cnt;
    logic          m_load, m_inc, m_acked;
    logic [AW-1:0] last_ack_addr;
    bit            mem_auto = 1'b0;
    int            max_wait = 0;
    int            wait_cnt = 0;

    m84_sample_ctrl #(.ADDR_W(AW), .ADDR_SHIFT(5)) dut (
        .CLK_32M(CLK_32M), .reset_n(reset_n),
        .sample_addr(sample_addr), .sample_addr_wr(sample_addr_wr),
        .sample_inc(sample_inc), .sample_out(sample_out),
        .sample_in(sample_in), .sample_ready(sample_ready), .dac_out(dac_out),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data)
    );

    always #5 CLK_32M = ~CLK_32M;

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5C;
    endfunction

    // One clock: optional auto memory response, model update, edge, pulse clear.
    task automatic step();
        if (mem_auto) begin
            if (rom_req && wait_cnt == 0) begin
                rom_ack  = 1'b1;
                rom_data = rom_byte(rom_addr);
                wait_cnt = $urandom_range(max_wait, 0);
            end else begin
                rom_ack = 1'b0;
                if (rom_req) wait_cnt--;
            end
        end
        m_acked = rom_ack && rom_req;
        if (m_acked) last_ack_addr = rom_addr;
        if (!reset_n) begin
            m_lo = 8'h00; m_hi = 8'h00; m_cnt = '0; m_dac = 8'h80;
            m_load = 1'b0; m_inc = 1'b0;
        end else begin
            m_load = |sample_addr_wr;
            m_inc  = sample_inc;
            if (sample_addr_wr[0]) m_lo = sample_addr;
            if (sample_addr_wr[1]) m_hi = sample_addr;
            if (m_load) m_cnt = AW'({16'h0000, m_hi, m_lo} << 5);
            else if (sample_inc) m_cnt = m_cnt + 18'd1;
            if (sample_inc) m_dac = sample_out;
        end
        @(posedge CLK_32M);
        #1;
        sample_addr_wr = 2'b00;
        sample_inc     = 1'b0;
        rom_ack        = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        for (int i = 0; i < bound && !sample_ready; i++) step();
        ok = sample_ready;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        for (int i = 0; i < bound && !rom_req; i++) step();
        ok = rom_req;
    endtask

    // Manual memory: wait for a request, then ack it with the given byte.
    task automatic serve(input logic [7:0] data, output logic [AW-1:0] addr, output bit ok);
        wait_req(10, ok);
        addr     = rom_addr;
        rom_ack  = ok;
        rom_data = data;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_auto = 1'b0;
        repeat (3) step();
        n_checks++; if (rom_req !== 1'b0) $display("FAIL reset_rom_req: got %0b want 0", rom_req); else n_pass++;
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", sample_ready); else n_pass++;
        n_checks++; if (sample_in !== 8'h00) $display("FAIL reset_sample_in: got %h want 00", sample_in); else n_pass++;
        n_checks++; if (dac_out !== 8'h80) $display("FAIL reset_dac: got %h want 80", dac_out); else n_pass++;
        n_checks++; if (rom_addr !== 18'h0) $display("FAIL reset_rom_addr: got %h want 0", rom_addr); else n_pass++;
    endtask

    task automatic test_first_fetch();
        reset_n = 1'b1;
        step();
        n_checks++; if (rom_req !== 1'b1 || rom_addr !== 18'h0) $display("FAIL first_req: got req=%0b addr=%h want 1/0", rom_req, rom_addr); else n_pass++;
        step();
        n_checks++; if (rom_req !== 1'b1 || sample_ready !== 1'b0) $display("FAIL first_hold: got req=%0b rdy=%0b want 1/0", rom_req, sample_ready); else n_pass++;
        rom_ack = 1'b1; rom_data = 8'h5A;
        step();
        n_checks++; if (sample_ready !== 1'b1 || sample_in !== 8'h5A) $display("FAIL first_data: got rdy=%0b data=%h want 1/5a", sample_ready, sample_in); else n_pass++;
        n_checks++; if (rom_req !== 1'b0) $display("FAIL first_req_drop: got %0b want 0", rom_req); else n_pass++;
    endtask

    task automatic test_load_fetch();
        logic [AW-1:0] stale, a;
        bit ok;
        sample_addr_wr = 2'b01; sample_addr = 8'h34;
        step();
        stale = m_cnt;
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL load_lo_ready: got %0b want 0", sample_ready); else n_pass++;
        sample_addr_wr = 2'b10; sample_addr = 8'h12;
        step();
        n_checks++; if (rom_req !== 1'b1 || rom_addr !== stale) $display("FAIL load_stale_req: got req=%0b addr=%h want 1/%h", rom_req, rom_addr, stale); else n_pass++;
        rom_ack = 1'b1; rom_data = 8'hEE;
        step();
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL load_discard: got rdy=%0b want 0", sample_ready); else n_pass++;
        serve(8'h77, a, ok);
        n_checks++; if (!ok || a !== m_cnt) $display("FAIL load_addr: got ok=%0b addr=%h want %h", ok, a, m_cnt); else n_pass++;
        n_checks++; if (sample_ready !== 1'b1 || sample_in !== 8'h77) $display("FAIL load_data: got rdy=%0b data=%h want 1/77", sample_ready, sample_in); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        mem_auto = 1'b1; max_wait = 2;
        sample_addr_wr = 2'b11; sample_addr = 8'hFF;
        step();
        repeat (31) begin
            sample_inc = 1'b1; sample_out = 8'($urandom);
            step();
        end
        wait_ready(20, ok);
        n_checks++; if (!ok || sample_in !== rom_byte(18'h3FFFF)) $display("FAIL wrap_top: got rdy=%0b data=%h want 1/%h", ok, sample_in, rom_byte(18'h3FFFF)); else n_pass++;
        sample_inc = 1'b1; sample_out = 8'hC3;
        step();
        n_checks++; if (dac_out !== 8'hC3 || sample_ready !== 1'b0) $display("FAIL wrap_inc: got dac=%h rdy=%0b want c3/0", dac_out, sample_ready); else n_pass++;
        wait_ready(20, ok);
        n_checks++; if (!ok || last_ack_addr !== 18'h0 || sample_in !== rom_byte(18'h0)) $display("FAIL wrap_zero: got rdy=%0b addr=%h data=%h want 1/0/%h", ok, last_ack_addr, sample_in, rom_byte(18'h0)); else n_pass++;
    endtask

    task automatic test_load_mid_fetch();
        logic [AW-1:0] a0, a;
        logic [7:0] want;
        bit ok;
        mem_auto = 1'b0;
        sample_addr_wr = 2'b01; sample_addr = 8'h10;
        step();
        step();
        a0 = rom_addr;
        n_checks++; if (rom_req !== 1'b1 || a0 !== m_cnt) $display("FAIL mid_req: got req=%0b addr=%h want 1/%h", rom_req, a0, m_cnt); else n_pass++;
        sample_addr_wr = 2'b01; sample_addr = 8'h20;
        step();
        n_checks++; if (rom_req !== 1'b1 || rom_addr !== a0) $display("FAIL mid_hold1: got req=%0b addr=%h want 1/%h", rom_req, rom_addr, a0); else n_pass++;
        step();
        n_checks++; if (rom_req !== 1'b1 || rom_addr !== a0) $display("FAIL mid_hold2: got req=%0b addr=%h want 1/%h", rom_req, rom_addr, a0); else n_pass++;
        rom_ack = 1'b1; rom_data = rom_byte(a0);
        step();
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL mid_discard: got rdy=%0b want 0", sample_ready); else n_pass++;
        want = rom_byte(m_cnt);
        serve(want, a, ok);
        n_checks++; if (!ok || a !== m_cnt) $display("FAIL mid_refetch: got ok=%0b addr=%h want %h", ok, a, m_cnt); else n_pass++;
        n_checks++; if (sample_ready !== 1'b1 || sample_in !== want) $display("FAIL mid_data: got rdy=%0b data=%h want 1/%h", sample_ready, sample_in, want); else n_pass++;
    endtask

    task automatic test_simul_load_inc();
        bit ok;
        mem_auto = 1'b1; max_wait = 1;
        sample_addr_wr = 2'b01; sample_addr = 8'h55;
        sample_inc = 1'b1; sample_out = 8'h3C;
        step();
        n_checks++; if (dac_out !== 8'h3C || sample_ready !== 1'b0) $display("FAIL simul_dac: got dac=%h rdy=%0b want 3c/0", dac_out, sample_ready); else n_pass++;
        wait_ready(20, ok);
        n_checks++; if (!ok || last_ack_addr !== m_cnt || sample_in !== rom_byte(m_cnt)) $display("FAIL simul_cnt: got rdy=%0b addr=%h want %h", ok, last_ack_addr, m_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        mem_auto = 1'b0;
        sample_addr_wr = 2'b10; sample_addr = 8'($urandom);
        step();
        step();
        n_checks++; if (rom_req !== 1'b1) $display("FAIL rstmid_req: got %0b want 1", rom_req); else n_pass++;
        reset_n = 1'b0;
        step();
        n_checks++; if (rom_req !== 1'b0 || sample_ready !== 1'b0 || dac_out !== 8'h80) $display("FAIL rstmid_drop: got req=%0b rdy=%0b dac=%h want 0/0/80", rom_req, sample_ready, dac_out); else n_pass++;
        reset_n = 1'b1;
    endtask

`ifdef M84_SAMPLE_PREFETCH_EN
    task automatic test_prefetch();
        bit ok;
        mem_auto = 1'b1; max_wait = 0;
        sample_addr_wr = 2'b11; sample_addr = 8'h21;
        step();
        wait_ready(20, ok);
        repeat (10) step();
        sample_inc = 1'b1; sample_out = 8'h99;
        step();
        n_checks++; if (sample_ready !== 1'b1 || sample_in !== rom_byte(m_cnt)) $display("FAIL pf_hit: got rdy=%0b data=%h want 1/%h", sample_ready, sample_in, rom_byte(m_cnt)); else n_pass++;
        wait_req(10, ok);
        n_checks++; if (!ok || rom_addr !== m_cnt + 18'd1) $display("FAIL pf_next: got req=%0b addr=%h want %h", ok, rom_addr, m_cnt + 18'd1); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic          p_req;
        logic [AW-1:0] p_addr;
        bit            ok;
        mem_auto = 1'b1; max_wait = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9, 0) == 0) begin
                sample_addr_wr = 2'($urandom_range(3, 1));
                sample_addr    = 8'($urandom);
            end
            if ($urandom_range(3, 0) == 0) begin
                sample_inc = 1'b1;
                sample_out = 8'($urandom);
            end
            p_req = rom_req; p_addr = rom_addr;
            step();
            n_checks++; if (dac_out !== m_dac) $display("FAIL rnd_dac: got %h want %h", dac_out, m_dac); else n_pass++;
            if (sample_ready) begin
                n_checks++; if (sample_in !== rom_byte(m_cnt)) $display("FAIL rnd_data: got %h want %h at %h", sample_in, rom_byte(m_cnt), m_cnt); else n_pass++;
            end
`ifdef M84_SAMPLE_PREFETCH_EN
            if (m_load && !(m_acked && last_ack_addr == m_cnt)) begin
`else
            if ((m_load || m_inc) && !(m_acked && last_ack_addr == m_cnt)) begin
`endif
                n_checks++; if (sample_ready !== 1'b0) $display("FAIL rnd_stall: got rdy=%0b want 0", sample_ready); else n_pass++;
            end
            if (p_req && !m_acked) begin
                n_checks++; if (rom_req !== 1'b1 || rom_addr !== p_addr) $display("FAIL rnd_req_hold: got req=%0b addr=%h want 1/%h", rom_req, rom_addr, p_addr); else n_pass++;
            end
        end
        wait_ready(30, ok);
        n_checks++; if (!ok || sample_in !== rom_byte(m_cnt)) $display("FAIL rnd_final: got rdy=%0b data=%h want 1/%h", ok, sample_in, rom_byte(m_cnt)); else n_pass++;
    endtask

    initial begin
        sample_addr = 8'h00; sample_addr_wr = 2'b00; sample_inc = 1'b0;
        sample_out = 8'h00; rom_ack = 1'b0; rom_data = 8'h00;
        last_ack_addr = '0; m_acked = 1'b0;
        test_reset();
        test_first_fetch();
        test_load_fetch();
        test_wrap();
        test_load_mid_fetch();
        test_simul_load_inc();
        test_reset_mid_fetch();
`ifdef M84_SAMPLE_PREFETCH_EN
        test_prefetch();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
